// File: rtl/tmr_time_redundant_sequencer_pkg.sv
// Shared definitions for the time-redundant TMR sequencer.
// Holds the FSM state encoding and the default widths and retry limit
// used by the sequencer top level.
package tmr_time_redundant_sequencer_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int OPW_DEF       = 5;
  localparam int MAX_RETRY_DEF = 2;
  localparam int CNTW_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC0 = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_VOTE  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/tmr_time_redundant_sequencer_sat_counter.sv
// Saturating up-counter for fault statistics.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high clear
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
module tmr_time_redundant_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/tmr_time_redundant_sequencer.sv
// Time-redundant TMR sequencer.
// Accepts one ALU request, runs it three times on a shared combinational
// ALU, hands the three captured copies to an external majority voter and
// retries the whole triple while the voter reports no majority, up to
// MAX_RETRY times. The voted result is returned with corrected/failed
// flags; saturating counters track corrected and failed responses.
// Ports:
//   clock, reset                   - clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_op - request handshake and operands
//   alu_a/alu_b/alu_op, alu_result - shared ALU interface
//   res0/res1/res2                 - captured copies to the voter
//   vote_out/vote_error/vote_invalid - voter verdict
//   out_valid/out_ready/out_result/out_corrected/out_failed - response
//   retry_count                    - retries used by current response
//   err_count/fail_count           - saturating fault counters
module tmr_time_redundant_sequencer
  import tmr_time_redundant_sequencer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int OPW       = OPW_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int CNTW      = CNTW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  input  logic [WIDTH-1:0] vote_out,
  input  logic             vote_error,
  input  logic             vote_invalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_corrected,
  output logic             out_failed,
  output logic [1:0]       retry_count,
  output logic [CNTW-1:0]  err_count,
  output logic [CNTW-1:0]  fail_count
);

  localparam logic [1:0] MAX_L = 2'(MAX_RETRY);

  state_e           state_q;
  logic [1:0]       attempt_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] res0_q, res1_q, res2_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_valid_q, out_corrected_q, out_failed_q;
  logic [1:0]       retry_count_q;
  logic             retry_ok;
  logic             err_inc, fail_inc;

  // The ALU operand registers double as the latched request: they are
  // loaded once at acceptance and simply held through every attempt.
  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign retry_ok = (attempt_q < MAX_L);
  assign err_inc  = (state_q == ST_VOTE) && !vote_invalid && vote_error;
  assign fail_inc = (state_q == ST_VOTE) && vote_invalid && !retry_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      attempt_q       <= '0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_op_q        <= '0;
      res0_q          <= '0;
      res1_q          <= '0;
      res2_q          <= '0;
      out_result_q    <= '0;
      out_valid_q     <= 1'b0;
      out_corrected_q <= 1'b0;
      out_failed_q    <= 1'b0;
      retry_count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            alu_a_q   <= in_a;
            alu_b_q   <= in_b;
            alu_op_q  <= in_op;
            attempt_q <= '0;
            state_q   <= ST_EXEC0;
          end
        end
        ST_EXEC0: begin
          res0_q  <= alu_result;
          state_q <= ST_EXEC1;
        end
        ST_EXEC1: begin
          res1_q  <= alu_result;
          state_q <= ST_EXEC2;
        end
        ST_EXEC2: begin
          res2_q  <= alu_result;
          state_q <= ST_VOTE;
        end
        ST_VOTE: begin
          if (vote_invalid && retry_ok) begin
            attempt_q <= attempt_q + 1'b1;
            state_q   <= ST_EXEC0;
          end else begin
            out_result_q    <= vote_out;
            out_corrected_q <= !vote_invalid && vote_error;
            out_failed_q    <= vote_invalid;
            retry_count_q   <= attempt_q;
            out_valid_q     <= 1'b1;
            state_q         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tmr_time_redundant_sequencer_sat_counter #(.W(CNTW)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

  tmr_time_redundant_sequencer_sat_counter #(.W(CNTW)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (fail_inc),
    .count (fail_count)
  );

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign res0          = res0_q;
  assign res1          = res1_q;
  assign res2          = res2_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_corrected = out_corrected_q;
  assign out_failed    = out_failed_q;
  assign retry_count   = retry_count_q;

endmodule
